// File: rtl/lut_replicator.sv
// lut_replicator: run-time loadable truth table (2^IN_W words of OUT_N bits)
// evaluated over a valid/ready stream with a one-cycle registered lookup and a
// saturating count of accepted vectors.
module lut_replicator #(
  parameter int IN_W  = 4,
  parameter int OUT_N = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic [OUT_N-1:0] cfg_data,
  output logic             cfg_done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_N-1:0] out_res,
  output logic [CNT_W-1:0] eval_cnt,
  output logic             busy_load
);

  localparam int unsigned DEPTH = 1 << IN_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IN_W-1:0]  r_addr;
  logic [OUT_N-1:0] r_table [DEPTH];
  logic [OUT_N-1:0] r_out_res;
  logic             r_out_valid;
  logic             r_cfg_done;
  logic [CNT_W-1:0] r_eval_cnt;

  logic             w_wr_en;
  logic             w_last_wr;
  logic             w_addr_clr;
  logic             w_in_ready;
  logic             w_accept;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and load-path controls; cfg_start in LOAD beats cfg_valid.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_last_wr   = 1'b0;
    w_addr_clr  = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (cfg_start) begin
          w_state_nxt = S_LOAD;
          w_addr_clr  = 1'b1;
        end
      end
      S_LOAD: begin
        if (cfg_start) begin
          w_addr_clr = 1'b1;
        end else if (cfg_valid) begin
          w_wr_en = 1'b1;
          if (&r_addr) begin
            w_last_wr   = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (cfg_start) begin
          w_state_nxt = S_LOAD;
          w_addr_clr  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // Load address: cleared on (re)start and after the final word, else advances per write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (w_addr_clr || w_last_wr) begin
      r_addr <= '0;
    end else if (w_wr_en) begin
      r_addr <= r_addr + IN_W'(1);
    end
  end

  // Truth-table storage; words survive a restarted load until overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_table[r_addr] <= cfg_data;
    end
  end

  // Load-complete pulse, one cycle after the last word is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_done <= 1'b0;
    end else begin
      r_cfg_done <= w_last_wr;
    end
  end

  // Input handshake: accept only in RUN with the output slot free or draining.
  always_comb begin
    w_in_ready = (r_state == S_RUN) && (!r_out_valid || out_ready);
    w_accept   = in_valid && w_in_ready;
  end

  // Output register: lookup on accept, hold under backpressure, drop when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_res   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_res   <= r_table[in_vec];
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Saturating evaluation counter, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eval_cnt <= '0;
    end else if (w_accept && (r_eval_cnt != '1)) begin
      r_eval_cnt <= r_eval_cnt + CNT_W'(1);
    end
  end

  assign cfg_done  = r_cfg_done;
  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_res   = r_out_res;
  assign eval_cnt  = r_eval_cnt;
  assign busy_load = (r_state == S_LOAD);

endmodule

// File: tb/tb_lut_replicator.sv
// Bench for lut_replicator: random and directed stimulus checked each cycle
// against a behavioural model; a second instance with CNT_W=4 shares the
// stimulus to exercise counter saturation.
module tb_lut_replicator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [2:0] cfg_data = '0;
  logic       in_valid = 1'b0;
  logic [3:0] in_vec = '0;
  logic       out_ready = 1'b0;

  logic       cfg_done, in_ready, out_valid, busy_load;
  logic [2:0] out_res;
  logic [7:0] eval_cnt;
  logic       cfg_done4, in_ready4, out_valid4, busy_load4;
  logic [2:0] out_res4;
  logic [3:0] eval_cnt4;

  lut_replicator #(.IN_W(4), .OUT_N(3), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_done(cfg_done), .in_valid(in_valid),
    .in_ready(in_ready), .in_vec(in_vec), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .eval_cnt(eval_cnt),
    .busy_load(busy_load)
  );

  lut_replicator #(.IN_W(4), .OUT_N(3), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_done(cfg_done4), .in_valid(in_valid),
    .in_ready(in_ready4), .in_vec(in_vec), .out_valid(out_valid4),
    .out_ready(out_ready), .out_res(out_res4), .eval_cnt(eval_cnt4),
    .busy_load(busy_load4)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 = no table, 1 = loading, 2 = running.
  int          mode;
  int unsigned wptr;
  logic [2:0]  mtab [16];
  logic        mvalid;
  logic [2:0]  mres;
  logic        mdone;
  int unsigned acc_total;
  int unsigned done_seen;
  logic [2:0]  newtab [16];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [2:0] lab_word(input logic [3:0] v);
    logic a, b, c, d, o2, o3;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    o2 = (a & c) | (b & d);
    o3 = (a | ~c) & (~b | d);
    return {o2 | o3, o2, o3};
  endfunction

  task automatic model_reset();
    mode = 0; wptr = 0; mvalid = 1'b0; mres = '0; mdone = 1'b0; acc_total = 0;
    for (int i = 0; i < 16; i++) mtab[i] = '0;
  endtask

  task automatic check_outputs();
    check_eq("out_valid", out_valid, mvalid);
    check_eq("out_res", out_res, mres);
    check_eq("cfg_done", cfg_done, mdone);
    check_eq("busy_load", busy_load, mode == 1);
    check_eq("eval_cnt", eval_cnt, sat(acc_total, 255));
    check_eq("out_valid4", out_valid4, mvalid);
    check_eq("out_res4", out_res4, mres);
    check_eq("eval_cnt4", eval_cnt4, sat(acc_total, 15));
    if (cfg_done) done_seen++;
  endtask

  // One clock: drive at the falling edge, check ready, advance model, check at next falling edge.
  task automatic step(input logic s, input logic v, input logic [2:0] d,
                      input logic iv, input logic [3:0] vec, input logic ordy);
    logic exp_rdy, acc;
    cfg_start = s; cfg_valid = v; cfg_data = d;
    in_valid = iv; in_vec = vec; out_ready = ordy;
    #1;
    exp_rdy = (mode == 2) && (!mvalid || ordy);
    check_eq("in_ready", in_ready, exp_rdy);
    check_eq("in_ready4", in_ready4, exp_rdy);
    acc = iv && exp_rdy;
    if (acc) begin
      mres = mtab[vec]; mvalid = 1'b1; acc_total++;
    end else if (ordy) begin
      mvalid = 1'b0;
    end
    mdone = 1'b0;
    if (mode == 1) begin
      if (s) wptr = 0;
      else if (v) begin
        mtab[wptr] = d;
        if (wptr == 15) begin wptr = 0; mode = 2; mdone = 1'b1; end
        else wptr++;
      end
    end else if (s) begin
      mode = 1; wptr = 0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic load_words(input int first, input int count, input logic ordy);
    for (int k = 0; k < count; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++)
        step(1'b0, 1'b0, 3'($urandom), 1'($urandom), 4'($urandom), ordy);
      step(1'b0, 1'b1, newtab[first + k], 1'($urandom), 4'($urandom), ordy);
    end
  endtask

  task automatic traffic(input int cycles);
    for (int c = 0; c < cycles; c++)
      step(1'b0, 1'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0),
           4'($urandom), 1'($urandom_range(0, 9) < 7));
  endtask

  initial begin
    logic [3:0] dvec [4];
    logic [2:0] dexp [4];
    int unsigned d0, a0;
    dvec[0] = 4'b1010; dexp[0] = 3'b111;
    dvec[1] = 4'b0000; dexp[1] = 3'b101;
    dvec[2] = 4'b0010; dexp[2] = 3'b000;
    dvec[3] = 4'b0100; dexp[3] = 3'b000;
    done_seen = 0;
    model_reset();

    // Reset, then EMPTY ignores vectors and stray cfg_valid.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
    check_eq("rst_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'($urandom), 1'b1, 4'($urandom), 1'b1);

    // Load the lab function table.
    for (int i = 0; i < 16; i++) newtab[i] = lab_word(4'(i));
    d0 = done_seen;
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    load_words(0, 16, 1'b1);
    check_eq("lab_done_once", done_seen - d0, 1);
    check_eq("ready_after_load", in_ready, 1'b1);

    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, dvec[i], 1'b1);
      check_eq($sformatf("lab_%b", dvec[i]), out_res, dexp[i]);
    end

    // Backpressure then random traffic.
    step(1'b0, 1'b0, '0, 1'b1, 4'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, 4'($urandom), 1'b0);
    a0 = acc_total;
    traffic(300);
    check_eq("enough_accepts", (acc_total - a0) >= 50, 1'b1);

    // Reload with a pending result, restart after 7 words.
    step(1'b0, 1'b0, '0, 1'b1, 4'b0110, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 4'b0110, 1'b0);
    check_eq("pending_kept", out_valid, 1'b1);
    for (int i = 0; i < 16; i++) newtab[i] = 3'($urandom);
    load_words(0, 7, 1'b0);
    check_eq("pending_held", out_valid, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    check_eq("pending_consumed", out_valid, 1'b0);
    d0 = done_seen;
    load_words(0, 15, 1'b1);
    check_eq("no_done_after_15", done_seen - d0, 0);
    check_eq("still_loading", busy_load, 1'b1);
    load_words(15, 1, 1'b1);
    check_eq("reload_done_once", done_seen - d0, 1);
    step(1'b0, 1'b0, '0, 1'b1, 4'b1010, 1'b1);
    check_eq("new_word", out_res, newtab[10]);
    traffic(150);

    // Saturation of both counters.
    for (int i = 0; i < 300; i++) step(1'b0, 1'b0, '0, 1'b1, 4'($urandom), 1'b1);
    check_eq("sat_cnt8", eval_cnt, 255);
    check_eq("sat_cnt4", eval_cnt4, 15);

    // Asynchronous reset mid-load with a result pending.
    step(1'b0, 1'b0, '0, 1'b1, 4'($urandom), 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) newtab[i] = 3'($urandom);
    load_words(0, 5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_eq("async_in_ready", in_ready, 1'b0);
    check_eq("async_cfg_done4", cfg_done4, 1'b0);
    check_eq("async_busy4", busy_load4, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'($urandom), 1'b1, 4'($urandom), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/lut_replicator.md
Name: lut_replicator

Overview:
- Programmable, registered successor to the fixed 4-input/3-output logic replicator.
- Holds a run-time loadable truth table: 2^IN_W entries, each OUT_N bits wide.
- Evaluates a stream of IN_W-bit input vectors through valid/ready handshakes and returns one OUT_N-bit result per accepted vector.
- Keeps a saturating count of evaluations. Sits between lab stimulus logic and display/checker logic.

Parameters:
- IN_W, 4, input vector width; table depth = 2^IN_W (range 1..8).
- OUT_N, 3, output functions per entry (bits per table word).
- CNT_W, 8, width of the evaluation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- cfg_start  input  1  one-cycle pulse; begin (re)loading the table.
- cfg_valid  input  1  cfg_data holds the next table word.
- cfg_data  input  OUT_N  table word for the current load address.
- cfg_done  output  1  one-cycle pulse when the last word is written.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block accepts in_vec this cycle.
- in_vec  input  IN_W  input vector (MSB = first variable, e.g. a).
- out_valid  output  1  out_res is valid.
- out_ready  input  1  downstream accepts out_res.
- out_res  output  OUT_N  table[in_vec] (MSB = out1).
- eval_cnt  output  CNT_W  accepted-vector count, saturating.
- busy_load  output  1  high while in LOAD.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous on the falling edge of rst_n, active-low.
- Reset values:
  - State is EMPTY.
  - All table words, out_res, out_valid, cfg_done, eval_cnt and the load address are 0.
  - in_ready and busy_load are 0.
- State machine: EMPTY, LOAD, RUN.
  - EMPTY: table not yet valid; in_ready=0. cfg_start moves to LOAD.
  - LOAD: busy_load=1, in_ready=0.
    - Each cycle with cfg_valid=1 writes cfg_data to table[addr] and increments addr.
    - The write at addr = 2^IN_W-1 pulses cfg_done on the next cycle, resets addr to 0 and moves to RUN.
    - cfg_start in LOAD restarts at addr 0. Words already written are kept, but the load is only complete after 2^IN_W further writes.
    - If cfg_start and cfg_valid coincide in LOAD, cfg_start wins and the word is dropped.
  - RUN: evaluation enabled. cfg_start moves to LOAD; the table is then invalid for lookups until cfg_done.
- cfg_valid is ignored outside LOAD.
- Handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - A vector is accepted when in_valid && in_ready.
  - On acceptance: out_res <= table[in_vec] and out_valid <= 1 at the next edge (1-cycle latency).
  - With out_ready held high, throughput is one vector per cycle.
  - out_valid drops on out_ready && !accept.
  - out_res and out_valid stay stable while out_valid && !out_ready.
- A pending result is not disturbed by entering LOAD. It stays valid until consumed by out_ready.
- eval_cnt increments by 1 per accepted vector and saturates at 2^CNT_W-1, with no wrap. It is cleared only by reset.
- Lookup is from registered table contents, so a write and a lookup never occur in the same cycle.
- Reset mid-load or mid-transfer aborts immediately to the reset values above.

Test Plan:
- Reset checks: rst_n low, then release → EMPTY, in_ready=0, out_valid=0, eval_cnt=0. Inputs with in_valid=1 while EMPTY are never accepted.
- Load the lab function table:
  - Table: out1=out2|out3, out2=ac|bd, out3=(a|~c)(~b|d); 16 cfg_valid words.
  - Required: cfg_done pulses once, then in_ready=1.
  - Sending in_vec 4'b1010 → 3'b111; 4'b0000 → 3'b101; 4'b0010 → 3'b000; 4'b0100 → 3'b000, each one cycle after acceptance.
- Backpressure: out_ready=0 with a result pending → in_ready=0 and out_res held. Raise out_ready → result consumed, next vector accepted in the same cycle; no loss or duplication over 50 random vectors.
- Reload and restart:
  - cfg_start in RUN with a result pending → pending result still delivered.
  - New table loaded; the same in_vec returns the new word.
  - cfg_start after 7 words restarts addr at 0; 16 more words are needed for cfg_done.
- Counter saturation: with CNT_W=4, accept 20 vectors → eval_cnt=15.
- Mid-load reset: async reset asserted mid-load and mid-transfer → outputs reach reset values immediately, not at the next clock edge.
